// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the signed product accumulator.
// Holds the FSM state enum and the default width parameters.
package prod_accum_pkg;

  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 72;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum.sv
// Accumulates a stream of signed 64-bit products into a guarded sum.
// Ports: clk, rst (async high), clr (sync abort);
//   in_valid/in_ready/in_product/in_last: beat input handshake;
//   out_valid/out_ready/out_sum/out_count/out_ovf: result handshake.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             take;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic [ACC_W-PROD_W:0] top_bits;

  // rst term keeps in_ready low while reset is held,
  // not just after the state register settles.
  assign in_ready = !rst && !clr && (state != HOLD);
  assign take     = in_valid && in_ready;

  assign ext  = ACC_W'($signed(in_product));
  assign base = (state == IDLE) ? '0 : acc;
  assign sum_nxt = base + ext;

  always_comb begin
    cnt_nxt = '0;
    if (state == IDLE) begin
      cnt_nxt = CNT_W'(1);
    end else if (&cnt) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Sum fits signed 64 bits only if bits ACC_W-1..63 agree.
  assign top_bits = sum_nxt[ACC_W-1:PROD_W-1];
  assign ovf_nxt  = !((&top_bits) || !(|top_bits));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (clr) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (take) begin
            if (in_last) begin
              out_sum   <= sum_nxt;
              out_count <= cnt_nxt;
              out_ovf   <= ovf_nxt;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc   <= sum_nxt;
              cnt   <= cnt_nxt;
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum.
// Inputs driven 1ns after rising edges; outputs sampled there too.
module tb_prod_accum;

  localparam int ACC_W = 72;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [63:0] p, input logic l);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    in_valid = 1'b0; in_product = '0; in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_ready", in_ready, 0);
    #11;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    // +5, -2, +10
    beat(64'd5, 1'b0);
    beat(-64'sd2, 1'b0);
    check("t1_no_early_valid", out_valid, 0);
    beat(64'd10, 1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 13);
    check("t1_count", out_count, 3);
    check("t1_ovf", out_ovf, 0);
    check("t1_hold_ready", in_ready, 0);
    idle_cycle();
    check("t1_release", out_valid, 0);
    check("t1_idle_ready", in_ready, 1);

    // positive overflow past signed 64
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check("t2_valid", out_valid, 1);
    check("t2_sum", out_sum, 72'h00_FFFF_FFFF_FFFF_FFFE);
    check("t2_count", out_count, 2);
    check("t2_ovf", out_ovf, 1);
    idle_cycle();

    // single beat, stalled downstream
    out_ready = 1'b0;
    beat(-64'sd4, 1'b1);
    in_valid = 1'b1; in_product = 64'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_ready", in_ready, 0);
      check("t3_valid", out_valid, 1);
      check("t3_sum", out_sum, 72'hFF_FFFF_FFFF_FFFF_FFFC);
      check("t3_count", out_count, 1);
      check("t3_ovf", out_ovf, 0);
      idle_cycle();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    idle_cycle();
    check("t3_release", out_valid, 0);
    check("t3_sum_kept", out_sum, 72'hFF_FFFF_FFFF_FFFF_FFFC);
    check("t3_idle_ready", in_ready, 1);

    // abort mid-frame, beat presented with clr is dropped
    beat(64'd7, 1'b0);
    beat(64'd7, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1; in_product = 64'd100; in_last = 1'b0;
    #1;
    check("t4_clr_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    check("t4_no_out", out_valid, 0);
    beat(64'd1, 1'b1);
    check("t4_valid", out_valid, 1);
    check("t4_sum", out_sum, 1);
    check("t4_count", out_count, 1);
    idle_cycle();

    // async reset mid-frame
    out_ready = 1'b0;
    beat(64'd9, 1'b0);
    beat(64'd3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_sum", out_sum, 0);
    check("t5_rst_count", out_count, 0);
    check("t5_rst_ready", in_ready, 0);
    #2;
    rst = 1'b0;
    idle_cycle();
    check("t5_ready", in_ready, 1);
    beat(64'd9, 1'b1);
    check("t5_valid", out_valid, 1);
    check("t5_sum", out_sum, 9);
    check("t5_count", out_count, 1);
    // clr is ignored while a result is pending
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    check("t5_clr_hold_valid", out_valid, 1);
    check("t5_clr_hold_sum", out_sum, 9);
    out_ready = 1'b1;
    idle_cycle();
    check("t5_release", out_valid, 0);

    // counter saturation
    in_valid = 1'b1; in_product = 64'd1; in_last = 1'b0;
    for (int i = 0; i < 69999; i++) begin
      @(posedge clk);
    end
    #1;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("t6_valid", out_valid, 1);
    check("t6_count", out_count, 65535);
    check("t6_sum", out_sum, 70000);
    check("t6_ovf", out_ovf, 0);
    idle_cycle();
    check("t6_release", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
